if_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage core; sits directly upstream of the IF/ID pipe register.

---
 rtl/if_stage.sv | 166 ++++++++++++++++
 tb/tb_if_stage.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of the 5-stage core, directly upstream of the IF/ID
// pipe register. It owns the PC and issues one outstanding request at a time
// on a req/gnt/rvalid instruction bus. It holds the returned word until ID
// takes it through the valid/ready_go/allow_in handshake. EX redirects
// (branch, jump, flush) are handled here, and a response that is already in
// flight when a redirect arrives is drained and dropped.
//
// Parameters
//   AW        PC / instruction address width
//   DW        instruction word width
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clk             in   core clock, all state on the rising edge
//   rst             in   asynchronous reset, active-high
//   jump_en         in   redirect request from EX
//   jump_addr       in   redirect target (bits [1:0] forced to zero)
//   allow_in_id     in   IF/ID register can accept this cycle
//   inst_req        out  instruction bus request
//   inst_addr       out  request address (current pc)
//   inst_gnt        in   request accepted this cycle
//   inst_rvalid     in   response valid (in order, >= 1 cycle after gnt)
//   inst_rdata      in   response word
//   pc_if           out  PC of the held instruction
//   instruction_if  out  held instruction
//   valid_if        out  stage holds a fetched instruction
//   ready_go_if     out  held instruction may advance
// ---------------------------------------------------------------------------
module if_stage #(
    parameter int              AW       = 32,
    parameter int              DW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          jump_en,
    input  logic [AW-1:0] jump_addr,
    input  logic          allow_in_id,
    output logic          inst_req,
    output logic [AW-1:0] inst_addr,
    input  logic          inst_gnt,
    input  logic          inst_rvalid,
    input  logic [DW-1:0] inst_rdata,
    output logic [AW-1:0] pc_if,
    output logic [DW-1:0] instruction_if,
    output logic          valid_if,
    output logic          ready_go_if
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_FULL = 2'd3;

    logic [1:0]    r_state;
    logic [AW-1:0] r_pc;
    logic          r_discard;
    logic [AW-1:0] r_pc_if;
    logic [DW-1:0] r_inst;

    logic [1:0]    w_state_nxt;
    logic [AW-1:0] w_pc_nxt;
    logic          w_discard_nxt;
    logic          w_capture;
    logic [AW-1:0] w_jump_target;
    logic [AW-1:0] w_pc_inc;

    assign w_jump_target = {jump_addr[AW-1:2], 2'b00};
    assign w_pc_inc      = r_pc + AW'(4);

    // A redirect takes priority over everything else in every state.
    // r_discard marks a bus response that is still owed for a request
    // issued before the redirect. Only one request is ever outstanding,
    // so a single flag is enough to track it.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_discard_nxt = r_discard;
        w_capture     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
                if (jump_en) begin
                    w_pc_nxt = w_jump_target;
                end
            end
            S_REQ: begin
                if (jump_en) begin
                    w_pc_nxt = w_jump_target;
                end
                // The bus accepted the old address on the same edge as the
                // redirect, so its response must be drained and dropped.
                if (inst_gnt) begin
                    w_state_nxt   = S_WAIT;
                    w_discard_nxt = jump_en;
                end
            end
            S_WAIT: begin
                if (jump_en) begin
                    w_pc_nxt = w_jump_target;
                    if (inst_rvalid) begin
                        w_state_nxt   = S_REQ;
                        w_discard_nxt = 1'b0;
                    end else begin
                        w_discard_nxt = 1'b1;
                    end
                end else if (inst_rvalid) begin
                    if (r_discard) begin
                        w_state_nxt   = S_REQ;
                        w_discard_nxt = 1'b0;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_FULL;
                    end
                end
            end
            S_FULL: begin
                // ready_go_if is low during a redirect, so a jump always
                // drops the held word instead of handing it to ID.
                if (jump_en) begin
                    w_pc_nxt    = w_jump_target;
                    w_state_nxt = S_REQ;
                end else if (allow_in_id) begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_discard <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_discard <= w_discard_nxt;
        end
    end

    // The held instruction and its PC change only when a response is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_if <= RESET_PC;
            r_inst  <= '0;
        end else if (w_capture) begin
            r_pc_if <= r_pc;
            r_inst  <= inst_rdata;
        end
    end

    assign inst_req       = (r_state == S_REQ);
    assign inst_addr      = r_pc;
    assign valid_if       = (r_state == S_FULL);
    assign ready_go_if    = valid_if & ~jump_en;
    assign pc_if          = r_pc_if;
    assign instruction_if = r_inst;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
// Random and directed stimulus for if_stage. The bench also acts as the
// instruction memory. Its reference model is architectural: ID must receive
// consecutive PCs starting at RESET_PC, and each redirect restarts the
// sequence at the target with the low two bits cleared. The driver pushes
// the expected {pc, word} pair whenever it lets a transfer happen. A separate
// monitor pops that pair when it sees the handshake and compares it with the
// outputs of the stage.
// ---------------------------------------------------------------------------
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk;
   logic        rst;
   logic        jump_en;
   logic [31:0] jump_addr;
   logic        allow_in_id;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_gnt;
   logic        inst_rvalid;
   logic [31:0] inst_rdata;
   logic [31:0] pc_if;
   logic [31:0] instruction_if;
   logic        valid_if;
   logic        ready_go_if;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   exp_t        expQ[$];
   logic [31:0] modelPc;
   bit          pending;
   logic [31:0] pendAddr;
   int          respDelay;
   int          checks;
   int          failures;
   int          xferCount;
   int          cycle;
   bit          zwStrict;

   bit          prevValid;
   bit          prevXfer;
   bit          prevJump;
   logic [31:0] prevPc;
   logic [31:0] prevInst;
   bit          haveStrict;
   int          lastStrictCycle;

   if_stage #(
      .AW       (32),
      .DW       (32),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .jump_en        (jump_en),
      .jump_addr      (jump_addr),
      .allow_in_id    (allow_in_id),
      .inst_req       (inst_req),
      .inst_addr      (inst_addr),
      .inst_gnt       (inst_gnt),
      .inst_rvalid    (inst_rvalid),
      .inst_rdata     (inst_rdata),
      .pc_if          (pc_if),
      .instruction_if (instruction_if),
      .valid_if       (valid_if),
      .ready_go_if    (ready_go_if)
   );

   // 10-unit clock period. Rising edges fall at 5, 15, 25, and so on.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Memory contents: each word address holds its own distinct value.
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return 32'h0010_0093 + (addr >> 2);
   endfunction

   task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic checkReset();
      checkVal("rst_inst_req", 32'(inst_req), 32'd0);
      checkVal("rst_valid_if", 32'(valid_if), 32'd0);
      checkVal("rst_ready_go", 32'(ready_go_if), 32'd0);
      checkVal("rst_pc_if", pc_if, RESET_PC);
      checkVal("rst_instruction", instruction_if, 32'd0);
   endtask

   task automatic driveIdle();
      jump_en     = 1'b0;
      jump_addr   = 32'd0;
      allow_in_id = 1'b0;
      inst_gnt    = 1'b0;
      inst_rvalid = 1'b0;
      inst_rdata  = 32'd0;
   endtask

   // Starts the model over from RESET_PC and forgets any bus response that is still owed.
   task automatic resetModel();
      modelPc = RESET_PC;
      expQ.delete();
      pending = 1'b0;
      respDelay = 0;
   endtask

   // One cycle of stimulus. Call it at a falling edge, once the outputs have settled.
   task automatic applyStimulus(input int unsigned gntPct, input int unsigned maxDelay,
                                input int unsigned allowPct, input int unsigned jumpPct,
                                input bit forceJump, input logic [31:0] forceAddr);
      bit busy;
      busy        = pending;
      inst_rvalid = 1'b0;
      inst_rdata  = $urandom;
      if (pending) begin
         if (respDelay == 0) begin
            inst_rvalid = 1'b1;
            inst_rdata  = memWord(pendAddr);
            pending     = 1'b0;
         end else begin
            respDelay--;
         end
      end
      inst_gnt = 1'b0;
      if (inst_req) begin
         checkVal("req_addr_aligned", 32'(inst_addr[1:0]), 32'd0);
         if (!busy && ($urandom_range(99) < gntPct)) begin
            inst_gnt  = 1'b1;
            pending   = 1'b1;
            pendAddr  = inst_addr;
            respDelay = int'($urandom_range(maxDelay));
         end
      end
      jump_en     = forceJump || ($urandom_range(99) < jumpPct);
      jump_addr   = forceJump ? forceAddr : ($urandom & 32'h0000_FFFF);
      allow_in_id = ($urandom_range(99) < allowPct);
      if (valid_if && !jump_en && allow_in_id) begin
         expQ.push_back('{pc: modelPc, word: memWord(modelPc)});
         modelPc = modelPc + 32'd4;
      end
      if (jump_en) begin
         modelPc = jump_addr & ~32'd3;
      end
   endtask

   task automatic runCycles(input int n, input int unsigned gntPct, input int unsigned maxDelay,
                            input int unsigned allowPct, input int unsigned jumpPct);
      repeat (n) begin
         @(negedge clk);
         applyStimulus(gntPct, maxDelay, allowPct, jumpPct, 1'b0, 32'd0);
      end
   endtask

   // Returns at a falling edge where the stage is requesting (wantReq) or
   // holding an instruction. Inputs for that cycle are not driven yet.
   task automatic waitState(input bit wantReq, input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!(wantReq ? inst_req : valid_if) && n < 30) begin
         if (wantReq) applyStimulus(0, 0, 100, 0, 1'b0, 32'd0);
         else         applyStimulus(100, 0, 0, 0, 1'b0, 32'd0);
         n++;
         @(negedge clk);
      end
      checks++;
      if (!(wantReq ? inst_req : valid_if)) begin
         failures++;
         $display("[TB] FAIL %s: timeout after %0d cycles waiting, required state not reached", name, n);
      end
   endtask

   // Monitor: samples shortly after each falling edge, once the driver has
   // set that cycle's inputs, and compares every handshake with the scoreboard.
   task automatic checkOutput();
      bit   xfer;
      exp_t e;
      xfer = valid_if && ready_go_if && allow_in_id;
      if (valid_if) begin
         checkVal("ready_go_rule", 32'(ready_go_if), 32'(!jump_en));
         checkVal("no_req_while_full", 32'(inst_req), 32'd0);
      end
      if (prevValid && !prevXfer && !prevJump) begin
         checkVal("hold_valid", 32'(valid_if), 32'd1);
         checkVal("hold_pc_if", pc_if, prevPc);
         checkVal("hold_instruction", instruction_if, prevInst);
      end
      if (xfer) begin
         xferCount++;
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_transfer: got pc %h, expected no transfer", pc_if);
         end else begin
            e = expQ.pop_front();
            checkVal("xfer_pc", pc_if, e.pc);
            checkVal("xfer_word", instruction_if, e.word);
         end
         if (zwStrict) begin
            if (haveStrict) checkVal("zero_wait_spacing", 32'(cycle - lastStrictCycle), 32'd3);
            haveStrict      = 1'b1;
            lastStrictCycle = cycle;
         end else begin
            haveStrict = 1'b0;
         end
      end
      prevValid = valid_if;
      prevXfer  = xfer;
      prevJump  = jump_en;
      prevPc    = pc_if;
      prevInst  = instruction_if;
   endtask

   always @(negedge clk) begin
      #2;
      if (rst) begin
         prevValid  = 1'b0;
         haveStrict = 1'b0;
      end else begin
         checkOutput();
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks    = 0;
      failures  = 0;
      xferCount = 0;
      zwStrict  = 1'b0;
      rst       = 1'b0;
      driveIdle();
      resetModel();

      // Assert reset between clock edges. The outputs must clear at once.
      #3 rst = 1'b1;
      #1 checkReset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      driveIdle();
      resetModel();
      #1 checkVal("idle_no_req", 32'(inst_req), 32'd0);
      @(posedge clk);
      #1;
      checkVal("first_req", 32'(inst_req), 32'd1);
      checkVal("first_addr", inst_addr, RESET_PC);

      // Zero-wait stream: one instruction every three cycles.
      zwStrict = 1'b1;
      runCycles(40, 100, 0, 100, 0);
      zwStrict = 1'b0;

      // ID stalls for five cycles while the stage is full, then accepts.
      waitState(1'b0, "wait_full_stall");
      applyStimulus(100, 0, 0, 0, 1'b0, 32'd0);
      runCycles(4, 100, 0, 0, 0);
      runCycles(10, 100, 0, 100, 0);

      // A redirect while waiting drops the in-flight word. The next request goes to 0x100.
      waitState(1'b1, "wait_req_t4");
      applyStimulus(100, 1, 100, 0, 1'b0, 32'd0);
      @(negedge clk);
      applyStimulus(0, 0, 100, 0, 1'b1, 32'h0000_0103);
      waitState(1'b1, "wait_req_after_jump");
      checkVal("jump_req_addr", inst_addr, 32'h0000_0100);
      applyStimulus(100, 0, 100, 0, 1'b0, 32'd0);
      runCycles(10, 100, 0, 100, 0);

      // A redirect while full, together with allow_in_id, blocks the transfer.
      waitState(1'b0, "wait_full_t5");
      applyStimulus(100, 0, 100, 0, 1'b1, 32'h0000_2000);
      waitState(1'b1, "wait_req_t5");
      checkVal("full_jump_req_addr", inst_addr, 32'h0000_2000);
      applyStimulus(100, 0, 100, 0, 1'b0, 32'd0);
      runCycles(10, 100, 0, 100, 0);

      // The PC wraps from the top of the address space back to zero.
      @(negedge clk);
      applyStimulus(100, 0, 100, 0, 1'b1, 32'hFFFF_FFFD);
      runCycles(12, 100, 0, 100, 0);

      // Random bus timing, ID backpressure and redirects.
      runCycles(600, 60, 3, 70, 8);
      runCycles(12, 100, 0, 100, 0);

      // Reset while a request is outstanding: nothing is captured, and fetch restarts at RESET_PC.
      waitState(1'b1, "wait_req_t6");
      applyStimulus(100, 3, 100, 0, 1'b0, 32'd0);
      @(negedge clk);
      applyStimulus(0, 0, 100, 0, 1'b0, 32'd0);
      #4 rst = 1'b1;
      #1 checkReset();
      resetModel();
      @(negedge clk);
      rst = 1'b0;
      driveIdle();
      resetModel();
      runCycles(15, 100, 0, 100, 0);

      @(negedge clk);
      driveIdle();
      #4;
      checkVal("scoreboard_drained", 32'(expQ.size()), 32'd0);
      checks++;
      if (xferCount < 40) begin
         failures++;
         $display("[TB] FAIL transfer_count: got %0d transfers, required at least 40", xferCount);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
